// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank arbiter: operation codes (J,K) and FSM states.
package jk_pkg;

  // Each op code is laid out as {J, K}, so the code drives the cell pins directly.
  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRIVE = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell, rising-edge, cleared by async active-low reset.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic J,
  input  logic K,
  output logic Q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies one requester's JK operation to one cell of
// a bank of N JK flip-flops, sequencing IDLE -> DRIVE -> DONE.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [IDX_W-1:0] idx0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [IDX_W-1:0] idx1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N-1:0]     q
);

  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N);

  state_t           state;
  op_t              op_q;
  logic [IDX_W-1:0] idx_q;
  logic             bad_q;
  logic             last_winner;

  logic             take0;
  logic             take1;
  logic [IDX_W-1:0] sel_idx;
  op_t              sel_op;
  logic             sel_bad;

  logic [N-1:0]     cell_j;
  logic [N-1:0]     cell_k;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    take0   = req0 && (!req1 || last_winner);
    take1   = req1 && !take0;
    sel_idx = take0 ? idx0 : idx1;
    sel_op  = take0 ? op_t'(op0) : op_t'(op1);
    sel_bad = ({1'b0, sel_idx} >= N_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= OP_HOLD;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      last_winner <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take0 || take1) begin
            op_q  <= sel_op;
            idx_q <= sel_idx;
            bad_q <= sel_bad;
            gnt0  <= take0;
            gnt1  <= take1;
            busy  <= 1'b1;
            state <= S_DRIVE;
            if (req0 && req1) last_winner <= take1;
          end
        end
        S_DRIVE: begin
          done  <= 1'b1;
          err   <= bad_q;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Only the latched cell sees the op's J/K, and only for the DRIVE cycle.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    cell_j = '0;
    cell_k = '0;
    if (state == S_DRIVE && !bad_q) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IDX_W'(i)) begin
          cell_j[i] = op_q[1];
          cell_k[i] = op_q[0];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .J     (cell_j[i]),
      .K     (cell_k[i]),
      .Q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: table-driven single ops, tie arbitration,
// out-of-range index on an N=3 instance and mid-operation reset.
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0  = 1'b0;
  logic       req1  = 1'b0;
  logic [1:0] op0   = 2'b00;
  logic [1:0] op1   = 2'b00;
  logic [1:0] idx0  = 2'b00;
  logic [1:0] idx1  = 2'b00;
  logic       gnt0, gnt1, busy, done, err;
  logic [3:0] q;

  logic       req1_3 = 1'b0;
  logic       gnt0_3, gnt1_3, busy_3, done_3, err_3;
  logic [2:0] q3;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.N(4), .IDX_W(2)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .op0(op0), .idx0(idx0),
    .req1(req1), .op1(op1), .idx1(idx1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .err(err), .q(q)
  );

  jk_bank_arbiter #(.N(3), .IDX_W(2)) dut3 (
    .clk(clk), .reset(rst_n),
    .req0(1'b0), .op0(2'b00), .idx0(2'b00),
    .req1(req1_3), .op1(op1), .idx1(idx1),
    .gnt0(gnt0_3), .gnt1(gnt1_3), .busy(busy_3), .done(done_3), .err(err_3), .q(q3)
  );

  typedef struct {
    bit         who;
    op_t        op;
    logic [1:0] idx;
    logic [3:0] exp_q;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       err;
  } cexp_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  bit    gq[$];
  cexp_t cq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: grants and completions are matched against queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0 && gnt1) check("gnt_onehot", 32'(gnt0 & gnt1), 0);
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) check("gnt_unexpected", gq.size(), 1);
        else check("gnt_who", 32'(gnt1), 32'(gq.pop_front()));
      end
      if (done) begin
        if (cq.size() == 0) begin
          check("done_unexpected", cq.size(), 1);
        end else begin
          cexp_t e;
          e = cq.pop_front();
          check("done_q", 32'(q), 32'(e.q));
          check("done_err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  // who: 0 = gnt0, 1 = gnt1, 2 = either.
  task automatic wait_gnt(input int who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((who == 0 && gnt0) || (who == 1 && gnt1) || (who == 2 && (gnt0 || gnt1))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 32'(ok), 1);
  endtask

  task automatic do_op(input bit who, input op_t op, input logic [1:0] idx,
                       input logic [3:0] exp_q, input logic exp_err);
    bit ok;
    int c0;
    gq.push_back(who);
    cq.push_back('{exp_q, exp_err});
    @(posedge clk); #1;
    c0 = cyc;
    if (!who) begin req0 = 1'b1; op0 = op; idx0 = idx; end
    else      begin req1 = 1'b1; op1 = op; idx1 = idx; end
    wait_gnt(int'(who), ok);
    req0 = 1'b0;
    req1 = 1'b0;
    if (ok) begin
      check("gnt_latency", cyc - c0, 1);
      check("busy_drive", 32'(busy), 1);
      @(negedge clk);
      check("done_pulse", 32'(done), 1);
      check("busy_done", 32'(busy), 1);
      @(negedge clk);
      check("busy_idle", 32'(busy), 0);
      check("done_low", 32'(done), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    bit   ok;
    int   last_c;

    vecs[0] = '{1'b0, OP_SET,    2'd2, 4'b0100, 1'b0};
    vecs[1] = '{1'b0, OP_TOGGLE, 2'd2, 4'b0000, 1'b0};
    vecs[2] = '{1'b0, OP_TOGGLE, 2'd2, 4'b0100, 1'b0};
    vecs[3] = '{1'b1, OP_CLEAR,  2'd2, 4'b0000, 1'b0};
    vecs[4] = '{1'b0, OP_HOLD,   2'd2, 4'b0000, 1'b0};
    vecs[5] = '{1'b1, OP_SET,    2'd3, 4'b1000, 1'b0};
    vecs[6] = '{1'b0, OP_SET,    2'd0, 4'b1001, 1'b0};
    vecs[7] = '{1'b1, OP_TOGGLE, 2'd3, 4'b0001, 1'b0};
    vecs[8] = '{1'b0, OP_CLEAR,  2'd0, 4'b0000, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_q", 32'(q), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_gnt", 32'({gnt0, gnt1}), 0);
    check("rst_q3", 32'(q3), 0);

    // Single-requester operations
    foreach (vecs[i]) do_op(vecs[i].who, vecs[i].op, vecs[i].idx, vecs[i].exp_q, vecs[i].exp_err);

    // Both requesters held: alternate grants, three cycles apart
    gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
    cq.push_back('{4'b0001, 1'b0}); cq.push_back('{4'b0011, 1'b0});
    cq.push_back('{4'b0010, 1'b0}); cq.push_back('{4'b0000, 1'b0});
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_TOGGLE; idx0 = 2'd0;
    req1 = 1'b1; op1 = OP_TOGGLE; idx1 = 2'd1;
    last_c = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(2, ok);
      if (k > 0) check("gnt_spacing", cyc - last_c, 3);
      last_c = cyc;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("tie_final_q", 32'(q), 0);

    // Out-of-range index on the N=3 instance
    @(posedge clk); #1;
    req1_3 = 1'b1; op1 = OP_SET; idx1 = 2'd3;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = gnt1_3;
    end
    check("n3_gnt1", 32'(ok), 1);
    req1_3 = 1'b0;
    @(negedge clk);
    check("n3_done", 32'(done_3), 1);
    check("n3_err", 32'(err_3), 1);
    check("n3_q", 32'(q3), 0);
    @(negedge clk);
    check("n3_err_clear", 32'({done_3, err_3}), 0);

    // Reset during DRIVE discards the operation
    do_op(1'b0, OP_SET, 2'd3, 4'b1000, 1'b0);
    gq.push_back(1'b0);
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_SET; idx0 = 2'd1;
    wait_gnt(0, ok);
    req0 = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_q", 32'(q), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_gnt", 32'(gnt0), 0);
    @(negedge clk);
    check("midrst_hold_q", 32'(q), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'({done, busy}), 0);
    end

    // First tie after reset goes to requester 0
    gq.push_back(1'b0); gq.push_back(1'b1);
    cq.push_back('{4'b0001, 1'b0}); cq.push_back('{4'b0011, 1'b0});
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_TOGGLE; idx0 = 2'd0;
    req1 = 1'b1; op1 = OP_TOGGLE; idx1 = 2'd1;
    wait_gnt(0, ok);
    req0 = 1'b0;
    wait_gnt(1, ok);
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_q", 32'(q), 32'h3);

    check("gq_drained", gq.size(), 0);
    check("cq_drained", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
